// File: rtl/pc_gen.sv
// Fetch program-counter unit: reset vector, trap/branch redirect, return-address stack, fetch handshake.
// Optional trace output of every pc_o update is enabled by defining PC_TRACE_EN.
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     INC       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            br_ctrl,
  input  logic [XLEN-1:0] br_addr,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            pc_stall,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_miss
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            miss_q, miss_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];

  logic            fire;
  logic            ras_full;
  logic            do_pop;
  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   top_inc;
  logic [PW-1:0]   top_dec;

  assign pc_o      = pc_q;
  assign pc_valid  = (state_q == RUN);
  assign ras_empty = (cnt_q == '0);
  assign ras_miss  = miss_q;

  always_comb begin
    fire     = pc_valid & fetch_ready & ~pc_stall;
    ras_full = (cnt_q == CW'(RAS_DEPTH));
    seq_pc   = pc_q + XLEN'(INC);
    top_inc  = top_q + PW'(1);
    top_dec  = top_q - PW'(1);
    do_pop   = 1'b0;

    state_d = state_q;
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    miss_d  = 1'b0;
    ras_d   = ras_q;

    case (state_q)
      BOOT: state_d = RUN;
      default: begin
        state_d = RUN;
        if (trap_valid) begin
          pc_d    = trap_vec & ~XLEN'(3);
          cnt_d   = '0;
          state_d = BUBBLE;
        end else if (br_ctrl) begin
          pc_d = br_addr & ~XLEN'(3);
        end else if (fire) begin
          do_pop = ret_pop & ~ras_empty;
          miss_d = ret_pop & ras_empty;
          pc_d   = do_pop ? ras_q[top_q] : seq_pc;
          // Call and return together: the popped slot is reused for the new return address.
          if (call_push && do_pop) begin
            ras_d[top_q] = seq_pc;
          end else if (call_push) begin
            top_d          = top_inc;
            ras_d[top_inc] = seq_pc;
            cnt_d          = ras_full ? cnt_q : cnt_q + CW'(1);
          end else if (do_pop) begin
            top_d = top_dec;
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      top_q   <= '0;
      cnt_q   <= '0;
      miss_q  <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      ras_q   <= ras_d;
    end
  end

`ifdef PC_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst && state_q != BOOT) begin
      $display("------------------------------");
      if (trap_valid)                      $display("PC_o = TRAP: %h", pc_q);
      else if (br_ctrl)                    $display("PC_o = BR_addr: %h", pc_q);
      else if (fire && ret_pop && !ras_empty) $display("PC_o = RAS: %h", pc_q);
      else if (fire)                       $display("PC_o = PC_next: %h", pc_q);
      else                                 $display("PC_o = stall: %h", pc_q);
    end
  end
`else
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by random traffic against a queue-based model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, br_ctrl, call_push, ret_pop, pc_stall, fetch_ready;
  logic [31:0] trap_vec, br_addr;
  logic [31:0] pc_o;
  logic        pc_valid, ras_empty, ras_miss;

  int errors = 0;
  int checks = 0;

  // Reference model: RAS as a bounded queue (back = most recent call).
  logic [31:0] m_pc;
  logic        m_valid, m_boot, m_miss;
  logic [31:0] m_ras [$];

  pc_gen #(
    .XLEN(32),
    .RESET_VEC(32'h100),
    .RAS_DEPTH(4),
    .INC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trap_valid(trap_valid),
    .trap_vec(trap_vec),
    .br_ctrl(br_ctrl),
    .br_addr(br_addr),
    .call_push(call_push),
    .ret_pop(ret_pop),
    .pc_stall(pc_stall),
    .fetch_ready(fetch_ready),
    .pc_o(pc_o),
    .pc_valid(pc_valid),
    .ras_empty(ras_empty),
    .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_o"}, pc_o, m_pc);
    chk({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_valid});
    chk({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    chk({tag, ".ras_miss"}, {31'b0, ras_miss}, {31'b0, m_miss});
  endtask

  task automatic model_reset();
    m_pc    = 32'h100;
    m_valid = 1'b0;
    m_boot  = 1'b1;
    m_miss  = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    logic        f;
    logic [31:0] ret;
    logic [31:0] tgt;
    if (!rst) begin
      model_reset();
      return;
    end
    m_miss = 1'b0;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
      return;
    end
    f = m_valid && fetch_ready && !pc_stall;
    if (trap_valid) begin
      m_pc = {trap_vec[31:2], 2'b00};
      m_ras.delete();
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (br_ctrl) begin
        m_pc = {br_addr[31:2], 2'b00};
      end else if (f) begin
        ret = m_pc + 32'd4;
        if (ret_pop && m_ras.size() > 0) begin
          tgt = m_ras.pop_back();
          if (call_push) m_ras.push_back(ret);
          m_pc = tgt;
        end else begin
          if (ret_pop) m_miss = 1'b1;
          if (call_push) begin
            m_ras.push_back(ret);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
          m_pc = ret;
        end
      end
    end
  endtask

  task automatic drive(input logic t, input logic [31:0] tv, input logic b, input logic [31:0] ba,
                       input logic c, input logic r, input logic s, input logic rdy);
    trap_valid = t; trap_vec = tv; br_ctrl = b; br_addr = ba;
    call_push = c; ret_pop = r; pc_stall = s; fetch_ready = rdy;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic branch_to(input logic [31:0] a, input string tag);
    drive(1'b0, 32'h0, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b1);
    step(tag);
  endtask

  task automatic call_here(input string tag);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(tag);
  endtask

  task automatic ret_here(input string tag);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(tag);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    #1;
    check_all("release");

    // Boot then sequential fetch
    step("boot");
    chk("boot_pc", pc_o, 32'h100);
    step("seq1");
    chk("seq1_pc", pc_o, 32'h104);
    step("seq2");
    chk("seq2_pc", pc_o, 32'h108);

    // Stall and ready
    branch_to(32'h10, "br10");
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall_pc", pc_o, 32'h10);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step("notready");
    chk("notready_pc", pc_o, 32'h10);
    idle();
    step("resume");
    chk("resume_pc", pc_o, 32'h14);

    // Branch overrides stall; trap overrides branch
    drive(1'b0, 32'h0, 1'b1, 32'h203, 1'b0, 1'b0, 1'b1, 1'b1);
    step("br_stall");
    chk("br_stall_pc", pc_o, 32'h200);
    call_here("call200");
    drive(1'b1, 32'h80, 1'b1, 32'h203, 1'b0, 1'b0, 1'b1, 1'b1);
    step("trap");
    chk("trap_pc", pc_o, 32'h80);
    chk("trap_valid", {31'b0, pc_valid}, 32'd0);
    chk("trap_empty", {31'b0, ras_empty}, 32'd1);
    idle();
    step("bubble");
    step("post_bubble");
    chk("post_bubble_pc", pc_o, 32'h84);

    // Call / return
    branch_to(32'h40, "br40");
    call_here("call40");
    branch_to(32'h60, "br60");
    call_here("call60");
    ret_here("ret1");
    chk("ret1_pc", pc_o, 32'h64);
    ret_here("ret2");
    chk("ret2_pc", pc_o, 32'h44);
    chk("ret2_empty", {31'b0, ras_empty}, 32'd1);
    ret_here("ret3");
    chk("ret3_miss", {31'b0, ras_miss}, 32'd1);
    chk("ret3_pc", pc_o, 32'h48);
    idle();
    step("miss_clear");

    // RAS overflow
    for (int i = 0; i < 5; i++) begin
      branch_to(32'h10 * i, "ovf_br");
      call_here("ovf_call");
    end
    ret_here("ovf_ret1"); chk("ovf_ret1_pc", pc_o, 32'h44);
    ret_here("ovf_ret2"); chk("ovf_ret2_pc", pc_o, 32'h34);
    ret_here("ovf_ret3"); chk("ovf_ret3_pc", pc_o, 32'h24);
    ret_here("ovf_ret4"); chk("ovf_ret4_pc", pc_o, 32'h14);
    ret_here("ovf_ret5"); chk("ovf_ret5_miss", {31'b0, ras_miss}, 32'd1);

    // Wrap and asynchronous reset between edges
    branch_to(32'hFFFF_FFFC, "brwrap");
    idle();
    step("wrap");
    chk("wrap_pc", pc_o, 32'h0);
    call_here("pre_areset");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("areset");
    chk("areset_pc", pc_o, 32'h100);
    #3;
    rst = 1'b1;
    step("reboot");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) == 0), $urandom, ($urandom_range(7) == 0), $urandom,
            ($urandom_range(3) == 0), ($urandom_range(3) == 0),
            ($urandom_range(4) == 0), ($urandom_range(3) != 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
